pond_read_stream: RTL and testbench

Read-side accessor for the pond memory. It walks a configurable 2-D loop nest, issues combinational read addresses to the pond, and captures the returned word into a 2-entry output FIFO. Results leave on a valid/ready stream toward the interconnect. The block is the consumer counterpart of the pond write path and sits between `lake_mem` and the tile's data output.

---
 rtl/pond_pkg.sv | 24 ++
 rtl/pond_out_fifo.sv | 61 ++++++
 rtl/pond_read_stream.sv | 156 +++++++++++++++
 tb/tb_pond_read_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pond_pkg.sv
// Shared pond definitions: default widths, the read-accessor configuration bundle
// and a small helper used by the loop-nest logic.
package pond_pkg;

  localparam int unsigned PondDataWidth   = 16;
  localparam int unsigned PondAddrWidth   = 5;
  localparam int unsigned PondConfigWidth = 16;
  localparam int unsigned PondIterSupport = 2;

  typedef struct packed {
    logic [1:0]                                       dimensionality;
    logic [PondIterSupport-1:0][PondConfigWidth-1:0]  ranges;
    logic [PondAddrWidth-1:0]                         starting_addr;
    logic [PondIterSupport-1:0][PondAddrWidth-1:0]    strides;
    logic [PondConfigWidth-1:0]                       sched_starting_addr;
    logic [PondIterSupport-1:0][PondConfigWidth-1:0]  sched_strides;
  } pond_acc_cfg_t;

  // A dim takes part in the nest only when its index is below dimensionality.
  function automatic logic dim_active(input logic [1:0] dims, input int idx);
    return idx < int'({30'd0, dims});
  endfunction

endpackage

// File: rtl/pond_out_fifo.sv
// Two-entry registered FIFO holding words read from the pond until the
// interconnect accepts them.
module pond_out_fifo #(
  parameter int unsigned Width = 16
) (
  input  logic             gclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  // A full FIFO never takes a push, even when a pop frees a slot this cycle.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pond_read_stream.sv
// Pond read accessor: walks a 2-D loop nest on a cycle schedule, issues read
// addresses and streams the returned words out through a 2-entry FIFO.
module pond_read_stream
  import pond_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = PondDataWidth,
  parameter int unsigned ADDR_WIDTH       = PondAddrWidth,
  parameter int unsigned CONFIG_WIDTH     = PondConfigWidth,
  parameter int unsigned ITERATOR_SUPPORT = PondIterSupport
) (
  input  logic                                   gclk,
  input  logic                                   rst_n,
  input  logic                                   clk_en,
  input  logic                                   flush,
  input  logic [CONFIG_WIDTH-1:0]                cycle_count,
  input  logic [1:0]                             dimensionality,
  input  logic [ITERATOR_SUPPORT*CONFIG_WIDTH-1:0] ranges,
  input  logic [ADDR_WIDTH-1:0]                  starting_addr,
  input  logic [ITERATOR_SUPPORT*ADDR_WIDTH-1:0] strides,
  input  logic [CONFIG_WIDTH-1:0]                sched_starting_addr,
  input  logic [ITERATOR_SUPPORT*CONFIG_WIDTH-1:0] sched_strides,
  output logic [ADDR_WIDTH-1:0]                  rd_addr,
  input  logic [DATA_WIDTH-1:0]                  rd_data,
  output logic [DATA_WIDTH-1:0]                  data_out,
  output logic                                   valid_out,
  input  logic                                   ready_in,
  output logic                                   done
);

  localparam int unsigned Dims = ITERATOR_SUPPORT;
  localparam int unsigned SelW = (Dims > 1) ? $clog2(Dims) : 1;
  localparam logic [CONFIG_WIDTH-1:0] CntOne = 1;

  logic [Dims-1:0][CONFIG_WIDTH-1:0] range_v, sched_stride_v;
  logic [Dims-1:0][ADDR_WIDTH-1:0]   stride_v;

  assign range_v        = ranges;
  assign stride_v       = strides;
  assign sched_stride_v = sched_strides;

  logic [Dims-1:0][CONFIG_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]             cur_addr_q, cur_addr_d;
  logic [CONFIG_WIDTH-1:0]           sched_q, sched_d;
  logic                              gate_q, gate_d;
  logic                              done_q, done_d;

  logic [Dims-1:0]         at_max;
  logic [SelW-1:0]         sel;
  logic                    last;
  logic [CONFIG_WIDTH-1:0] sched_addr;
  logic                    fifo_full, fifo_empty;
  logic                    fire, pop;
  logic [ADDR_WIDTH-1:0]   addr_rewind, addr_prod;
  logic [CONFIG_WIDTH-1:0] sched_rewind, sched_prod;

  assign rd_addr    = starting_addr + cur_addr_q;
  assign sched_addr = sched_starting_addr + sched_q;
  assign done       = done_q;
  assign valid_out  = ~fifo_empty;
  assign pop        = valid_out & ready_in & clk_en;

  // Inactive dims count as saturated so they never become the stepping dim.
  always_comb begin
    for (int i = 0; i < int'(Dims); i++) begin
      at_max[i] = !dim_active(dimensionality, i) || (cnt_q[i] == range_v[i]);
    end
  end

  always_comb begin
    sel  = '0;
    last = 1'b1;
    for (int i = int'(Dims) - 1; i >= 0; i--) begin
      if (!at_max[i]) begin
        sel  = i[SelW-1:0];
        last = 1'b0;
      end
    end
  end

  // Late issue is allowed: the >= lets a stalled slot catch up instead of being lost.
  assign fire = gate_q & (cycle_count >= sched_addr) & ~fifo_full & clk_en & ~flush
              & (dimensionality != 2'd0);

  // Strides are per-dim weights: stepping dim sel rewinds every saturated lower dim
  // back to zero and adds the weight of dim sel.
  always_comb begin
    cnt_d        = cnt_q;
    cur_addr_d   = cur_addr_q;
    sched_d      = sched_q;
    gate_d       = gate_q;
    done_d       = done_q;
    addr_rewind  = '0;
    sched_rewind = '0;
    addr_prod    = '0;
    sched_prod   = '0;
    if (flush) begin
      cnt_d      = '0;
      cur_addr_d = '0;
      sched_d    = '0;
      gate_d     = 1'b1;
      done_d     = 1'b0;
    end else if (fire) begin
      if (last) begin
        cnt_d      = '0;
        cur_addr_d = '0;
        sched_d    = '0;
        gate_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        for (int i = 0; i < int'(Dims); i++) begin
          if (i < int'(sel)) begin
            addr_prod    = cnt_q[i][ADDR_WIDTH-1:0] * stride_v[i];
            sched_prod   = cnt_q[i] * sched_stride_v[i];
            addr_rewind  = addr_rewind + addr_prod;
            sched_rewind = sched_rewind + sched_prod;
            cnt_d[i]     = '0;
          end
        end
        cnt_d[sel] = cnt_q[sel] + CntOne;
        cur_addr_d = cur_addr_q - addr_rewind + stride_v[sel];
        sched_d    = sched_q - sched_rewind + sched_stride_v[sel];
      end
    end
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_addr_q <= '0;
      sched_q    <= '0;
      gate_q     <= 1'b1;
      done_q     <= 1'b0;
    end else if (clk_en) begin
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      sched_q    <= sched_d;
      gate_q     <= gate_d;
      done_q     <= done_d;
    end
  end

  pond_out_fifo #(
    .Width (DATA_WIDTH)
  ) u_out_fifo (
    .gclk      (gclk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (rd_data),
    .pop       (pop),
    .flush     (flush & clk_en),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (data_out)
  );

endmodule

// File: tb/tb_pond_read_stream.sv
// Directed bench for pond_read_stream: a queue-based model of the loop nest and
// output FIFO is compared every cycle, plus literal checks per scenario.
module tb_pond_read_stream;

  logic        gclk;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic [15:0] cycle_count;
  logic [1:0]  cfg_dim;
  logic [15:0] r0, r1, sst, ss0, ss1;
  logic [4:0]  sa, s0, s1;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state.
  logic [4:0]  m_off[$];
  logic [15:0] m_sched[$];
  logic [15:0] m_q[$];
  int          m_k = 0;
  bit          m_done = 1'b0;

  // Observed DUT activity.
  logic [15:0] out_data[$];
  int          out_cyc[$];
  logic [4:0]  addr_at [64];
  int          done_cyc = -1;
  logic [4:0]  exp_addr[$];

  pond_read_stream dut (
    .gclk                (gclk),
    .rst_n               (rst_n),
    .clk_en              (clk_en),
    .flush               (flush),
    .cycle_count         (cycle_count),
    .dimensionality      (cfg_dim),
    .ranges              ({r1, r0}),
    .starting_addr       (sa),
    .strides             ({s1, s0}),
    .sched_starting_addr (sst),
    .sched_strides       ({ss1, ss0}),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .data_out            (data_out),
    .valid_out           (valid_out),
    .ready_in            (ready_in),
    .done                (done)
  );

  function automatic logic [15:0] mem_word(input logic [4:0] a);
    return 16'h1000 + {11'd0, a} * 16'h0101;
  endfunction

  assign rd_data = mem_word(rd_addr);

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Enumerate the nest directly: dim 0 innermost, address and slot are weighted sums.
  task automatic build_model();
    int n0, n1;
    m_off.delete();
    m_sched.delete();
    n1 = (cfg_dim >= 2) ? int'(r1) : 0;
    n0 = (cfg_dim >= 1) ? int'(r0) : 0;
    for (int i1 = 0; i1 <= n1; i1++) begin
      for (int i0 = 0; i0 <= n0; i0++) begin
        m_off.push_back(5'(i0 * int'(s0) + i1 * int'(s1)));
        m_sched.push_back(16'(int'(sst) + i0 * int'(ss0) + i1 * int'(ss1)));
      end
    end
  endtask

  always @(negedge gclk) begin : monitor
    int   sz;
    bit   f;
    logic [4:0] ea;
    if (!rst_n) begin
      m_q.delete();
      m_k    = 0;
      m_done = 1'b0;
      check("rst_valid", valid_out, 1'b0);
      check("rst_data", data_out, 16'h0);
      check("rst_done", done, 1'b0);
      check("rst_addr", rd_addr, sa);
    end else begin
      ea = sa + m_off[m_k];
      check("rd_addr", rd_addr, ea);
      check("valid_out", valid_out, m_q.size() != 0);
      if (m_q.size() != 0) check("data_out", data_out, m_q[0]);
      check("done", done, m_done);
      if (clk_en && cyc < 64) addr_at[cyc] = rd_addr;
      if (clk_en && !flush && valid_out && ready_in) begin
        out_data.push_back(data_out);
        out_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (clk_en) begin
        if (flush) begin
          m_q.delete();
          m_k    = 0;
          m_done = 1'b0;
        end else begin
          sz = m_q.size();
          f  = !m_done && cfg_dim != 2'd0 && cycle_count >= m_sched[m_k] && sz < 2;
          if (sz > 0 && ready_in) void'(m_q.pop_front());
          if (f) begin
            m_q.push_back(mem_word(ea));
            m_k++;
            if (m_k == m_off.size()) begin
              m_k    = 0;
              m_done = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge gclk);
    #1;
    if (clk_en) cyc++;
    cycle_count = cyc[15:0];
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    out_data.delete();
    out_cyc.delete();
    done_cyc = -1;
    for (int i = 0; i < 64; i++) addr_at[i] = 5'h0;
  endtask

  task automatic start_test();
    build_model();
    flush = 1'b1;
    step();
    flush = 1'b0;
    cyc = 0;
    cycle_count = 16'd0;
    clear_logs();
  endtask

  task automatic cfg_basic();
    cfg_dim = 2'd1; r0 = 16'd3; r1 = 16'd0; sa = 5'd4; s0 = 5'd1; s1 = 5'd0;
    sst = 16'd10; ss0 = 16'd1; ss1 = 16'd0;
  endtask

  task automatic check_out(input string nm, input int first_cyc);
    check({nm, "_count"}, out_data.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < out_data.size()) begin
        check({nm, "_word"}, out_data[i], mem_word(exp_addr[i]));
        if (first_cyc >= 0) check({nm, "_when"}, out_cyc[i], first_cyc + i);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; ready_in = 1'b1; cycle_count = 16'd0;
    cfg_basic();
    build_model();
    clear_logs();
    repeat (3) @(posedge gclk);
    #1 rst_n = 1'b1;

    // Single dim, four reads on slots 10..13.
    cfg_basic();
    start_test();
    run(20);
    for (int i = 0; i < 4; i++) check("t1_addr", addr_at[10+i], 5'(4 + i));
    exp_addr = '{5'd4, 5'd5, 5'd6, 5'd7};
    check_out("t1", 11);
    check("t1_done_cyc", done_cyc, 14);

    // Two dims: 3 x 2 nest with dim-1 weight 8.
    cfg_dim = 2'd2; r0 = 16'd2; r1 = 16'd1; sa = 5'd0; s0 = 5'd1; s1 = 5'd8;
    sst = 16'd2; ss0 = 16'd1; ss1 = 16'd3;
    start_test();
    run(15);
    exp_addr = '{5'd0, 5'd1, 5'd2, 5'd8, 5'd9, 5'd10};
    check_out("t2", 3);

    // Backpressure: hold ready low through cycle 15.
    cfg_basic();
    start_test();
    ready_in = 1'b0;
    run(16);
    ready_in = 1'b1;
    run(10);
    check("t3_stall_addr", addr_at[12], 5'd6);
    check("t3_late_addr", addr_at[17], 5'd6);
    exp_addr = '{5'd4, 5'd5, 5'd6, 5'd7};
    check_out("t3", 16);
    check("t3_done_cyc", done_cyc, 19);

    // Address wrap past 31.
    cfg_basic();
    sa = 5'd30; sst = 16'd1;
    start_test();
    run(12);
    exp_addr = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int i = 0; i < 4; i++) check("t4_addr", addr_at[1+i], exp_addr[i]);
    check_out("t4", 2);

    // Flush after two reads, then restart from the top.
    cfg_basic();
    start_test();
    run(12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_valid", valid_out, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_addr", rd_addr, 5'd4);
    cyc = 0;
    cycle_count = 16'd0;
    clear_logs();
    run(20);
    exp_addr = '{5'd4, 5'd5, 5'd6, 5'd7};
    check_out("t5", 11);

    // Clock enable low for three cycles mid-stream.
    cfg_basic();
    start_test();
    run(11);
    clk_en = 1'b0;
    run(3);
    check("t6_hold_valid", valid_out, 1'b1);
    check("t6_hold_data", data_out, mem_word(5'd4));
    check("t6_hold_addr", rd_addr, 5'd5);
    clk_en = 1'b1;
    run(15);
    check_out("t6", 11);
    check("t6_done_cyc", done_cyc, 14);

    // Zero dimensionality never fires.
    cfg_basic();
    cfg_dim = 2'd0;
    start_test();
    run(20);
    check("t7_done", done, 1'b0);
    check("t7_count", out_data.size(), 0);

    // Asynchronous reset mid-stream discards buffered data.
    cfg_basic();
    ready_in = 1'b0;
    start_test();
    run(12);
    #3 rst_n = 1'b0;
    #1;
    check("t8_valid", valid_out, 1'b0);
    check("t8_done", done, 1'b0);
    run(2);
    rst_n = 1'b1;
    ready_in = 1'b1;
    run(10);
    check("t8_done_after", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
